debounce_fsm: RTL and testbench
===============================

// Module: debounce_fsm
// PURPOSE
//  Debounces one asynchronous mechanical input (button/switch) using the periodic one-cycle
//  tick produced by the timer stage. Consumes timer `done` as `tick`.
//  Produces a clean level plus single-cycle rise/fall pulses for downstream control logic.
// PARAMETERS
//  SETTLE_TICKS  4   consecutive ticks the synced input must hold stable to accept; >=1
//  SYNC_STAGES   2   flops in the input synchroniser; >=2
//  GLITCH_W      8   width of glitch counter (used only when DEBOUNCE_GLITCH_CNT_EN)
// PORTS
//  clk         in   1         system clock
//  reset_n     in   1         asynchronous, active-low reset
//  tick        in   1         one-clk strobe from timer done; sampling time base
//  noisy_in    in   1         raw asynchronous input
//  db_level    out  1         debounced level, registered
//  rise_pulse  out  1         1-clk pulse on accepted 0->1
//  fall_pulse  out  1         1-clk pulse on accepted 1->0
//  busy        out  1         1 while in a WAIT state
//  glitch_clr  in   1         sync clear of glitch_cnt
//  glitch_cnt  out  GLITCH_W  saturating count of rejected transitions
// BEHAVIOUR
//  Reset: sync chain=0, state=S_LOW, cnt=0; db_level=0, rise/fall_pulse=0, busy=0, glitch_cnt=0.
//  sync_in = last flop of SYNC_STAGES chain; all FSM decisions use sync_in only.
//  cnt width = $clog2(SETTLE_TICKS+1); cnt cleared on every WAIT entry.
//  S_LOW : sync_in=1 -> S_WAIT_HI (cnt=0). Ticks in the entry cycle are not counted.
//  S_WAIT_HI: sync_in=0 -> S_LOW (glitch; takes priority over a same-cycle tick);
//          else tick & cnt==SETTLE_TICKS-1 -> S_HIGH; else tick -> cnt+1.
//  S_HIGH: mirror of S_LOW (sync_in=0 -> S_WAIT_LO).
//  S_WAIT_LO: mirror of S_WAIT_HI (revert -> S_HIGH; accept -> S_LOW).
//  db_level=1 exactly in S_HIGH/S_WAIT_LO; registered with state.
//  rise_pulse high for exactly the first clk db_level reads 1; fall_pulse likewise for 0.
//  rise/fall never both high. busy=1 in WAIT states only.
//  Latency from stable edge at noisy_in: SYNC_STAGES + 1 clk to WAIT entry,
//  then SETTLE_TICKS ticks; db_level changes the clk after the accepting tick.
//  tick held high continuously: every clk counts (degenerate fast mode, legal).
//  tick=0 forever: FSM may sit in WAIT indefinitely; no timeout.
//  Reset asserted mid-WAIT: immediate return to reset values, no pulse emitted.
// CONFIGURATION
//  DEBOUNCE_GLITCH_CNT_EN defined: glitch_cnt +1 on each WAIT->origin revert, saturates at
//   all-ones; glitch_clr has priority over a same-cycle increment.
//  Undefined: glitch_cnt tied 0, glitch_clr ignored; ports remain for a stable interface.
// STRUCTURE
//  debounce_pkg: state typedef enum {S_LOW,S_WAIT_HI,S_HIGH,S_WAIT_LO} (2-bit),
//   localparam for state encoding width.
//  Sub-module sync_ff_chain #(STAGES) for the input synchroniser; FSM, counter, pulse
//   generation and glitch counter live in debounce_fsm.
// TESTING (SETTLE_TICKS=4, SYNC_STAGES=2, tick every 10 clk from timer finalval=9)
//  1. Reset, noisy_in=0 -> db_level=0, busy=0, no pulses for 100 clk.
//  2. noisy_in 0->1 held -> busy after 3 clk; db_level=1 clk after 4th tick;
//     rise_pulse exactly 1 clk.
//  3. 1-clk-wide 1 pulses every 15 clk from low -> db_level stays 0;
//     glitch_cnt increments per pulse (macro on) / stays 0 (macro off).
//  4. Revert in same clk as 4th tick -> returns to S_LOW, no rise_pulse.
//  5. Assert reset_n=0 in S_WAIT_LO -> db_level=0 immediately, no fall_pulse.
//  6. tick tied 1 -> accept after 2+1+4 clk; glitch_cnt saturates at 255 then glitch_clr -> 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types for the mechanical-input debouncer: state encoding and state decode helpers.
package debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_e;

  // Debounced level implied by a state: high while accepted-high or confirming a fall.
  function automatic logic level_of(input state_e s);
    logic lvl;
    case (s)
      S_HIGH:    lvl = 1'b1;
      S_WAIT_LO: lvl = 1'b1;
      S_LOW:     lvl = 1'b0;
      S_WAIT_HI: lvl = 1'b0;
      default:   lvl = 1'b0;
    endcase
    return lvl;
  endfunction

  function automatic logic is_wait(input state_e s);
    logic w;
    case (s)
      S_WAIT_HI: w = 1'b1;
      S_WAIT_LO: w = 1'b1;
      S_LOW:     w = 1'b0;
      S_HIGH:    w = 1'b0;
      default:   w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/debounce_fsm_sync_ff_chain.sv
// Multi-flop synchroniser bringing an asynchronous input into the clk domain.
module sync_ff_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the raw input through the chain; only the last flop is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
    end
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/debounce_fsm.sv
// Tick-paced debouncer FSM with clean level, rise/fall pulses and busy flag.
// Optional rejected-transition counter enabled by defining DEBOUNCE_GLITCH_CNT_EN.
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int SETTLE_TICKS = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int GLITCH_W     = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic                noisy_in,
  output logic                db_level,
  output logic                rise_pulse,
  output logic                fall_pulse,
  output logic                busy,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int              CNT_W    = $clog2(SETTLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_in_s;
  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             revert_s;
  logic             lvl_nxt_s;
  logic             db_level_r;
  logic             rise_pulse_r;
  logic             fall_pulse_r;
  logic             busy_r;

  sync_ff_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (noisy_in),
    .q       (sync_in_s)
  );

  // Next-state and settle-counter logic; a revert beats a same-cycle tick.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    revert_s    = 1'b0;
    case (state_r)
      S_LOW: begin
        if (sync_in_s) begin
          state_nxt_s = S_WAIT_HI;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = S_LOW;
        end
      end
      S_WAIT_HI: begin
        if (!sync_in_s) begin
          state_nxt_s = S_LOW;
          revert_s    = 1'b1;
        end else if (tick && (cnt_r == CNT_LAST)) begin
          state_nxt_s = S_HIGH;
          cnt_nxt_s   = '0;
        end else if (tick) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      S_HIGH: begin
        if (!sync_in_s) begin
          state_nxt_s = S_WAIT_LO;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = S_HIGH;
        end
      end
      S_WAIT_LO: begin
        if (sync_in_s) begin
          state_nxt_s = S_HIGH;
          revert_s    = 1'b1;
        end else if (tick && (cnt_r == CNT_LAST)) begin
          state_nxt_s = S_LOW;
          cnt_nxt_s   = '0;
        end else if (tick) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = S_LOW;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign lvl_nxt_s = level_of(state_nxt_s);

  // State, counter and outputs all register together so level and pulses line up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_LOW;
      cnt_r        <= '0;
      db_level_r   <= 1'b0;
      rise_pulse_r <= 1'b0;
      fall_pulse_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      db_level_r   <= lvl_nxt_s;
      rise_pulse_r <= lvl_nxt_s & ~db_level_r;
      fall_pulse_r <= ~lvl_nxt_s & db_level_r;
      busy_r       <= is_wait(state_nxt_s);
    end
  end

  assign db_level   = db_level_r;
  assign rise_pulse = rise_pulse_r;
  assign fall_pulse = fall_pulse_r;
  assign busy       = busy_r;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_cnt_r;

  // Saturating count of rejected transitions; clear wins over a same-cycle revert.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      glitch_cnt_r <= '0;
    end else if (glitch_clr) begin
      glitch_cnt_r <= '0;
    end else if (revert_s && (glitch_cnt_r != {GLITCH_W{1'b1}})) begin
      glitch_cnt_r <= glitch_cnt_r + GLITCH_W'(1);
    end else begin
      glitch_cnt_r <= glitch_cnt_r;
    end
  end

  assign glitch_cnt = glitch_cnt_r;
`else
  logic unused_s;

  assign unused_s   = glitch_clr ^ revert_s;
  assign glitch_cnt = '0;
`endif

endmodule

// File: tb/tb_debounce_fsm.sv
// Directed bench for debounce_fsm (SETTLE_TICKS=4, SYNC_STAGES=2); follows DEBOUNCE_GLITCH_CNT_EN.
module tb_debounce_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       noisy_in;
  logic       glitch_clr;
  logic       db_level;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  logic seen_s;
  logic seen_b;

`ifdef DEBOUNCE_GLITCH_CNT_EN
  localparam bit GC_EN = 1'b1;
`else
  localparam bit GC_EN = 1'b0;
`endif

  debounce_fsm #(
    .SETTLE_TICKS (4),
    .SYNC_STAGES  (2),
    .GLITCH_W     (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (tick),
    .noisy_in   (noisy_in),
    .db_level   (db_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .busy       (busy),
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] gexp(input int n);
    return GC_EN ? 32'(n) : 32'd0;
  endfunction

  // One clock with the given tick value; outputs are stable on return.
  task automatic adv(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // Timer-style tick: one strobe every 10 clocks.
  task automatic periodic(input int n);
    for (int i = 0; i < n; i++) begin
      adv(phase == 9);
      phase = (phase + 1) % 10;
      seen_s = seen_s | db_level | rise_pulse | fall_pulse;
      seen_b = seen_b | busy;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    tick       = 1'b0;
    noisy_in   = 1'b0;
    glitch_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(db_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rise", 32'(rise_pulse), 32'd0);
    check("rst_fall", 32'(fall_pulse), 32'd0);
    check("rst_gcnt", 32'(glitch_cnt), 32'd0);

    // 1: idle low for 100 clocks
    reset_n = 1'b1;
    seen_s = 1'b0; seen_b = 1'b0;
    periodic(100);
    check("idle_quiet", 32'(seen_s | seen_b), 32'd0);

    // 2: clean rise then clean fall
    noisy_in = 1'b1;
    adv(1'b0); adv(1'b0);
    check("rise_busy_early", 32'(busy), 32'd0);
    adv(1'b0);
    check("rise_busy_3clk", 32'(busy), 32'd1);
    adv(1'b1); adv(1'b0); adv(1'b0); adv(1'b1); adv(1'b0); adv(1'b1);
    check("rise_3ticks_lvl", 32'(db_level), 32'd0);
    check("rise_3ticks_pulse", 32'(rise_pulse), 32'd0);
    adv(1'b1);
    check("rise_accept_lvl", 32'(db_level), 32'd1);
    check("rise_accept_pulse", 32'(rise_pulse), 32'd1);
    check("rise_accept_busy", 32'(busy), 32'd0);
    adv(1'b0);
    check("rise_pulse_1clk", 32'(rise_pulse), 32'd0);
    check("rise_hold_lvl", 32'(db_level), 32'd1);
    noisy_in = 1'b0;
    adv(1'b0); adv(1'b0); adv(1'b0);
    check("fall_busy", 32'(busy), 32'd1);
    adv(1'b1); adv(1'b1); adv(1'b1);
    check("fall_3ticks_lvl", 32'(db_level), 32'd1);
    adv(1'b1);
    check("fall_accept_lvl", 32'(db_level), 32'd0);
    check("fall_accept_pulse", 32'(fall_pulse), 32'd1);
    check("fall_accept_rise", 32'(rise_pulse), 32'd0);
    adv(1'b0);
    check("fall_pulse_1clk", 32'(fall_pulse), 32'd0);

    // 3: single-clock spikes from low are rejected
    phase = 0;
    for (int i = 1; i <= 4; i++) begin
      seen_s = 1'b0; seen_b = 1'b0;
      noisy_in = 1'b1;
      periodic(1);
      noisy_in = 1'b0;
      periodic(14);
      check("spike_quiet", 32'(seen_s), 32'd0);
      check("spike_busy_seen", 32'(seen_b), 32'd1);
      check("spike_gcnt", 32'(glitch_cnt), gexp(i));
    end

    // 4: revert coincides with the would-be accepting tick
    noisy_in = 1'b1;
    adv(1'b0); adv(1'b0); adv(1'b0);
    check("race_busy", 32'(busy), 32'd1);
    adv(1'b1); adv(1'b1);
    noisy_in = 1'b0;
    adv(1'b1); adv(1'b0);
    check("race_pre_busy", 32'(busy), 32'd1);
    adv(1'b1);
    check("race_lvl", 32'(db_level), 32'd0);
    check("race_rise", 32'(rise_pulse), 32'd0);
    check("race_busy_off", 32'(busy), 32'd0);
    check("race_gcnt", 32'(glitch_cnt), gexp(5));
    seen_s = 1'b0;
    for (int i = 0; i < 6; i++) begin
      adv(1'b1);
      seen_s = seen_s | db_level | rise_pulse;
    end
    check("race_after", 32'(seen_s), 32'd0);

    // 5: reset while confirming a fall
    noisy_in = 1'b1;
    repeat (7) adv(1'b1);
    check("wlo_setup_lvl", 32'(db_level), 32'd1);
    noisy_in = 1'b0;
    adv(1'b0); adv(1'b0); adv(1'b0);
    check("wlo_busy", 32'(busy), 32'd1);
    adv(1'b1); adv(1'b1);
    reset_n = 1'b0;
    #1;
    check("wlo_rst_lvl", 32'(db_level), 32'd0);
    check("wlo_rst_busy", 32'(busy), 32'd0);
    check("wlo_rst_fall", 32'(fall_pulse), 32'd0);
    check("wlo_rst_gcnt", 32'(glitch_cnt), 32'd0);
    adv(1'b1); adv(1'b1);
    reset_n = 1'b1;
    seen_s = 1'b0;
    for (int i = 0; i < 8; i++) begin
      adv(1'b1);
      seen_s = seen_s | db_level | rise_pulse | fall_pulse | busy;
    end
    check("wlo_post_quiet", 32'(seen_s), 32'd0);

    // 6: tick tied high
    noisy_in = 1'b1;
    repeat (6) adv(1'b1);
    check("fast_6clk_lvl", 32'(db_level), 32'd0);
    check("fast_6clk_busy", 32'(busy), 32'd1);
    adv(1'b1);
    check("fast_7clk_lvl", 32'(db_level), 32'd1);
    check("fast_7clk_rise", 32'(rise_pulse), 32'd1);
    noisy_in = 1'b0;
    repeat (7) adv(1'b1);
    check("fast_fall_lvl", 32'(db_level), 32'd0);
    check("fast_fall_pulse", 32'(fall_pulse), 32'd1);
    for (int i = 0; i < 300; i++) begin
      noisy_in = 1'b1;
      adv(1'b1);
      noisy_in = 1'b0;
      adv(1'b1);
    end
    repeat (4) adv(1'b1);
    check("sat_gcnt", 32'(glitch_cnt), gexp(255));
    check("sat_lvl", 32'(db_level), 32'd0);
    glitch_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      noisy_in = 1'b1;
      adv(1'b1);
      check("clr_prio_a", 32'(glitch_cnt), 32'd0);
      noisy_in = 1'b0;
      adv(1'b1);
      check("clr_prio_b", 32'(glitch_cnt), 32'd0);
    end
    repeat (4) adv(1'b1);
    glitch_clr = 1'b0;
    adv(1'b1);
    check("clr_hold", 32'(glitch_cnt), 32'd0);
    noisy_in = 1'b1;
    adv(1'b1);
    noisy_in = 1'b0;
    repeat (5) adv(1'b1);
    check("clr_resume", 32'(glitch_cnt), gexp(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
